// File: rtl/adpll_pkg.sv
// Shared encodings for the ADPLL loop controller: loop states, correction
// directions and default code geometry.
// Pure declarations; no ports, no latency, no flow control.
package adpll_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COARSE = 2'd1,
      ST_FINE   = 2'd2,
      ST_LOCKED = 2'd3
   } loop_state_t;

   // NONE doubles as "aligned / no correction" and as "no history yet".
   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } dir_t;

   localparam int DEF_CODE_W    = 10;
   localparam int DEF_CODE_INIT = 512;

endpackage

// File: rtl/adpll_code_sat.sv
// Saturating code +/- step for the DCO tuning word.
// Latency: combinational. Backpressure: none.
// Ports: code/step in, up/dn select (neither = pass-through), code_nxt out.
module adpll_code_sat
   import adpll_pkg::*;
#(
   parameter int CODE_W = DEF_CODE_W
) (
   input  logic [CODE_W-1:0] code,
   input  logic [CODE_W-1:0] step,
   input  logic              up,
   input  logic              dn,
   output logic [CODE_W-1:0] code_nxt
);

   logic [CODE_W:0] sum;
   logic [CODE_W:0] diff;

   // One extra bit exposes carry (overflow) and borrow (underflow).
   assign sum  = {1'b0, code} + {1'b0, step};
   assign diff = {1'b0, code} - {1'b0, step};

   always_comb begin
      code_nxt = code;
      if (up) begin
         code_nxt = sum[CODE_W] ? {CODE_W{1'b1}} : sum[CODE_W-1:0];
      end else if (dn) begin
         code_nxt = diff[CODE_W] ? '0 : diff[CODE_W-1:0];
      end
   end

endmodule

// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: phase-detector lead/lag -> DCO code, with
// acquisition (binary-halving step), fine tracking and lock detection.
// Latency: ref_rise -> dco_code/code_upd = 2 clk. Backpressure: none.
// Ports: enable, ref_rise, lead, lag in; dco_code, code_upd, locked, loop_state out.
module adpll_loop_ctrl
   import adpll_pkg::*;
#(
   parameter int CODE_W      = DEF_CODE_W,
   parameter int CODE_INIT   = DEF_CODE_INIT,
   parameter int COARSE_STEP = 64,
   parameter int LOCK_CNT    = 16,
   parameter int UNLOCK_CNT  = 4,
   parameter int CNT_W       = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              ref_rise,
   input  logic              lead,
   input  logic              lag,
   output logic [CODE_W-1:0] dco_code,
   output logic              code_upd,
   output logic              locked,
   output logic [1:0]        loop_state
);

   localparam logic [CODE_W-1:0] INIT_C  = CODE_W'(CODE_INIT);
   localparam logic [CODE_W-1:0] STEP_C  = CODE_W'(COARSE_STEP);
   localparam logic [CODE_W-1:0] ONE_C   = CODE_W'(1);
   localparam logic [CNT_W-1:0]  LOCK_C  = CNT_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0]  ULOCK_C = CNT_W'(UNLOCK_CNT);

   loop_state_t       state_q, state_n;
   dir_t              last_dir_q, last_dir_n;
   dir_t              dir_cur;
   logic [CODE_W-1:0] code_q, code_n, code_calc;
   logic [CODE_W-1:0] step_q, step_n, apply_step, half_step;
   logic [CNT_W-1:0]  good_q, good_n, same_q, same_n;
   logic              code_upd_q, locked_q, ref_rise_d1;
   logic              eval, is_move, is_rev, is_same, do_move;

   // Direction decode; lead+lag together is treated as aligned.
   always_comb begin
      dir_cur = DIR_NONE;
      if (lead && !lag) dir_cur = DIR_DOWN;
      else if (lag && !lead) dir_cur = DIR_UP;
   end

   assign eval      = ref_rise_d1;
   assign is_move   = (dir_cur != DIR_NONE);
   assign is_same   = is_move && (dir_cur == last_dir_q);
   assign is_rev    = is_move && (last_dir_q != DIR_NONE) && (dir_cur != last_dir_q);
   assign half_step = step_q >> 1;

   always_comb begin
      state_n    = state_q;
      step_n     = step_q;
      last_dir_n = last_dir_q;
      good_n     = good_q;
      same_n     = same_q;
      apply_step = step_q;
      do_move    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_n    = ST_COARSE;
               step_n     = STEP_C;
               last_dir_n = DIR_NONE;
            end
         end

         ST_COARSE: begin
            if (eval && is_move) begin
               do_move    = 1'b1;
               last_dir_n = dir_cur;
               if (is_rev) begin
                  // A reversal applies the halved step at once. Once that
                  // applied step is 2 or less, the next halving would be 1,
                  // so acquisition ends here and tracking continues at 1.
                  apply_step = half_step;
                  if (half_step <= CODE_W'(2)) begin
                     state_n = ST_FINE;
                     step_n  = ONE_C;
                     good_n  = '0;
                  end else begin
                     step_n = half_step;
                  end
               end
            end
         end

         ST_FINE: begin
            apply_step = ONE_C;
            if (eval) begin
               if (is_move) begin
                  do_move    = 1'b1;
                  last_dir_n = dir_cur;
               end
               if (is_same) begin
                  good_n = '0;
               end else if (good_q + CNT_W'(1) == LOCK_C) begin
                  state_n = ST_LOCKED;
                  good_n  = '0;
                  same_n  = '0;
               end else begin
                  good_n = good_q + CNT_W'(1);
               end
            end
         end

         ST_LOCKED: begin
            apply_step = ONE_C;
            if (eval) begin
               if (is_move) begin
                  do_move    = 1'b1;
                  last_dir_n = dir_cur;
                  // same_cnt is the length of the current same-direction
                  // run; a reversal starts a new run of length 1.
                  if (is_same) begin
                     if (same_q + CNT_W'(1) == ULOCK_C) begin
                        state_n    = ST_COARSE;
                        step_n     = STEP_C;
                        last_dir_n = DIR_NONE;
                        same_n     = '0;
                     end else begin
                        same_n = same_q + CNT_W'(1);
                     end
                  end else begin
                     same_n = CNT_W'(1);
                  end
               end else begin
                  same_n = '0;
               end
            end
         end

         default: state_n = ST_IDLE;
      endcase

      // Disable wins over everything, including a pending evaluation.
      if (!enable) begin
         state_n    = ST_IDLE;
         step_n     = STEP_C;
         last_dir_n = DIR_NONE;
         good_n     = '0;
         same_n     = '0;
         do_move    = 1'b0;
      end
   end

   adpll_code_sat #(
      .CODE_W (CODE_W)
   ) u_code_sat (
      .code     (code_q),
      .step     (apply_step),
      .up       (dir_cur == DIR_UP),
      .dn       (dir_cur == DIR_DOWN),
      .code_nxt (code_calc)
   );

   assign code_n = do_move ? code_calc : code_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         step_q      <= STEP_C;
         last_dir_q  <= DIR_NONE;
         good_q      <= '0;
         same_q      <= '0;
         code_q      <= INIT_C;
         code_upd_q  <= 1'b0;
         locked_q    <= 1'b0;
         ref_rise_d1 <= 1'b0;
      end else begin
         state_q     <= state_n;
         step_q      <= step_n;
         last_dir_q  <= last_dir_n;
         good_q      <= good_n;
         same_q      <= same_n;
         ref_rise_d1 <= ref_rise;
         locked_q    <= (state_n == ST_LOCKED);
         // Reload is silent: code_upd only flags loop corrections.
         if (!enable || state_q == ST_IDLE) begin
            code_q     <= INIT_C;
            code_upd_q <= 1'b0;
         end else begin
            code_q     <= code_n;
            code_upd_q <= (code_n != code_q);
         end
      end
   end

   assign dco_code   = code_q;
   assign code_upd   = code_upd_q;
   assign locked     = locked_q;
   assign loop_state = state_q;

endmodule
